// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the byte-wide data cache.
// Holds the controller state encoding and index/tag width derivation.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE_BACK,
        MEM_READ,
        UPDATE
    } state_t;

    localparam int ADDR_BITS   = 32;
    localparam int OFFSET_BITS = 2;

    function automatic int index_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_bits(input int num_sets);
        return ADDR_BITS - OFFSET_BITS - $clog2(num_sets);
    endfunction

endpackage

// File: rtl/dcache_byte_store_if.sv
// Bus bundles around the cache: requester side (byte accesses) and
// memory side (32-bit block beats with busywait handshake).
interface dcache_cpu_if;
    logic        cachemem_read;
    logic        cachemem_write;
    logic [31:0] cachemem_address;
    logic [7:0]  cachemem_writedata;
    logic [7:0]  cachemem_readdata;
    logic        cachemem_busyWait;

    modport master (
        output cachemem_read, cachemem_write,
        output cachemem_address, cachemem_writedata,
        input  cachemem_readdata, cachemem_busyWait
    );

    modport slave (
        input  cachemem_read, cachemem_write,
        input  cachemem_address, cachemem_writedata,
        output cachemem_readdata, cachemem_busyWait
    );
endinterface

interface dcache_mem_if;
    logic        mem_read;
    logic        mem_write;
    logic [29:0] mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    modport master (
        output mem_read, mem_write, mem_address, mem_writedata,
        input  mem_readdata, mem_busywait
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_writedata,
        output mem_readdata, mem_busywait
    );
endinterface

// File: rtl/dcache_line_array.sv
// Storage for the cache: data, tag, valid and dirty per set.
// Ports: one index, combinational read, sync byte-write / line-fill, sync clear.
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int NUM_SETS = 8,
    localparam int IW = index_bits(NUM_SETS),
    localparam int TW = tag_bits(NUM_SETS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [IW-1:0] index,
    output logic [31:0]   rd_line,
    output logic [TW-1:0] rd_tag,
    output logic          rd_valid,
    output logic          rd_dirty,
    input  logic          byte_we,
    input  logic [1:0]    byte_off,
    input  logic [7:0]    byte_data,
    input  logic          fill_we,
    input  logic [31:0]   fill_line,
    input  logic [TW-1:0] fill_tag
);

    logic [31:0]         data_q [NUM_SETS];
    logic [TW-1:0]       tag_q  [NUM_SETS];
    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;

    assign rd_line  = data_q[index];
    assign rd_tag   = tag_q[index];
    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];

    // Contents are left undefined across reset; only flags are cleared.
    always_ff @(posedge clock) begin
        if (fill_we) begin
            data_q[index] <= fill_line;
            tag_q[index]  <= fill_tag;
        end else if (byte_we) begin
            data_q[index][{byte_off, 3'b000} +: 8] <= byte_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (byte_we) begin
            dirty_q[index] <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache_byte_store.sv
// Direct-mapped, write-back, write-allocate byte cache; hit logic and FSM.
// Ports: clock, reset, cpu (byte request slave), mem (block port master).
module dcache_byte_store
    import dcache_pkg::*;
#(
    parameter int NUM_SETS    = 8,
    parameter int BLOCK_BYTES = 4
) (
    input logic         clock,
    input logic         reset,
    dcache_cpu_if.slave cpu,
    dcache_mem_if.master mem
);

    localparam int IW = index_bits(NUM_SETS);
    localparam int TW = tag_bits(NUM_SETS);

    if (BLOCK_BYTES != 4 || NUM_SETS < 2 ||
        (NUM_SETS & (NUM_SETS - 1)) != 0) begin : g_bad_cfg
        $error("dcache_byte_store: unsupported geometry");
    end

    state_t state_q, state_d;
    logic   first_q;
    logic [29:0] miss_q;

    logic [31:0]   addr;
    logic [1:0]    off;
    logic [IW-1:0] cur_idx, arr_idx;
    logic [TW-1:0] cur_tag;
    logic          req, hit;

    logic [31:0]   rd_line;
    logic [TW-1:0] rd_tag;
    logic          rd_valid, rd_dirty;
    logic          byte_we, fill_we;

    logic          mem_read, mem_write, busy;
    logic [29:0]   mem_addr;
    logic [7:0]    rdata;

    assign addr    = cpu.cachemem_address;
    assign off     = addr[1:0];
    assign cur_idx = addr[IW+1:2];
    assign cur_tag = addr[31:IW+2];
    assign req     = cpu.cachemem_read | cpu.cachemem_write;

    // Outside IDLE the array serves the latched miss line so a
    // withdrawn request cannot redirect an in-flight transfer.
    assign arr_idx = (state_q == IDLE) ? cur_idx : miss_q[IW-1:0];
    assign hit     = rd_valid & (rd_tag == cur_tag);

    dcache_line_array #(.NUM_SETS(NUM_SETS)) u_lines (
        .clock     (clock),
        .reset     (reset),
        .index     (arr_idx),
        .rd_line   (rd_line),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .byte_we   (byte_we),
        .byte_off  (off),
        .byte_data (cpu.cachemem_writedata),
        .fill_we   (fill_we),
        .fill_line (mem.mem_readdata),
        .fill_tag  (miss_q[29:IW])
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            first_q <= (state_d != state_q);
        end
    end

    always_ff @(posedge clock) begin
        if (state_q == IDLE && req && !hit) begin
            miss_q <= addr[31:2];
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = miss_q;
        busy      = 1'b0;
        rdata     = 8'h00;
        byte_we   = 1'b0;
        fill_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        // Read wins when both strobes are high.
                        if (cpu.cachemem_read) begin
                            rdata = rd_line[{off, 3'b000} +: 8];
                        end else begin
                            byte_we = 1'b1;
                        end
                    end else begin
                        busy    = 1'b1;
                        state_d = rd_dirty ? WRITE_BACK : MEM_READ;
                    end
                end
            end
            WRITE_BACK: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                mem_addr  = {rd_tag, miss_q[IW-1:0]};
                // Completion only counts after the entry cycle.
                if (!first_q && !mem.mem_busywait) begin
                    state_d = MEM_READ;
                end
            end
            MEM_READ: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                if (!first_q && !mem.mem_busywait) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                busy    = 1'b1;
                fill_we = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cpu.cachemem_readdata = rdata;
    assign cpu.cachemem_busyWait = busy;
    assign mem.mem_read          = mem_read;
    assign mem.mem_write         = mem_write;
    assign mem.mem_address       = mem_addr;
    assign mem.mem_writedata     = rd_line;

endmodule

// File: tb/tb_dcache_byte_store.sv
// Bench for dcache_byte_store: vector table with scoreboard queue,
// behavioural block memory, and a reset-during-fetch sequence.
module tb_dcache_byte_store;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    dcache_cpu_if cpu_if ();
    dcache_mem_if mem_if ();

    dcache_byte_store #(.NUM_SETS(8), .BLOCK_BYTES(4)) dut (
        .clock (clk),
        .reset (reset),
        .cpu   (cpu_if),
        .mem   (mem_if)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
        logic        exp_miss;
        logic        exp_wb;
        logic [29:0] wb_addr;
        logic [31:0] wb_data;
        logic [29:0] fetch_addr;
    } vec_t;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
    } wb_t;

    localparam int LAT = 3;

    int vectors = 0;
    int errors  = 0;

    vec_t vecs [18];
    vec_t exp_q [$];
    wb_t  wb_q [$];

    logic [31:0] mem_arr [256];
    logic        act, op, done;
    int          cnt;
    int          fetch_cnt = 0;
    logic [29:0] last_fetch;

    // Behavioural memory: busywait rises the cycle after a request,
    // stays high LAT cycles, then the beat completes once.
    always @(posedge clk) begin
        if (reset || !(mem_if.mem_read || mem_if.mem_write)) begin
            act <= 1'b0;
            done <= 1'b0;
            mem_if.mem_busywait <= 1'b0;
        end else if (!act || op != mem_if.mem_write) begin
            act <= 1'b1;
            op <= mem_if.mem_write;
            done <= 1'b0;
            mem_if.mem_busywait <= 1'b1;
            cnt <= LAT - 1;
        end else if (!done) begin
            if (cnt != 0) begin
                cnt <= cnt - 1;
            end else begin
                mem_if.mem_busywait <= 1'b0;
                done <= 1'b1;
                if (mem_if.mem_write) begin
                    mem_arr[mem_if.mem_address[7:0]] <= mem_if.mem_writedata;
                    wb_q.push_back('{mem_if.mem_address,
                                     mem_if.mem_writedata});
                end else begin
                    mem_if.mem_readdata <= mem_arr[mem_if.mem_address[7:0]];
                    last_fetch <= mem_if.mem_address;
                    fetch_cnt <= fetch_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && mem_if.mem_read && mem_if.mem_write) begin
            errors++;
            $display("FAIL rd_wr_overlap: both mem_read and mem_write high");
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int   f0;
        bit   busy_seen;
        bit   fin;
        logic [7:0] got;
        vec_t e;
        wb_t  w;
        @(posedge clk);
        #1;
        cpu_if.cachemem_read      = v.rd;
        cpu_if.cachemem_write     = v.wr;
        cpu_if.cachemem_address   = v.addr;
        cpu_if.cachemem_writedata = v.wdata;
        exp_q.push_back(v);
        f0 = fetch_cnt;
        busy_seen = 1'b0;
        fin = 1'b0;
        got = 8'h00;
        for (int c = 0; c < 60 && !fin; c++) begin
            @(negedge clk);
            if (cpu_if.cachemem_busyWait) busy_seen = 1'b1;
            else begin
                fin = 1'b1;
                got = cpu_if.cachemem_readdata;
            end
        end
        @(posedge clk);
        #1;
        cpu_if.cachemem_read  = 1'b0;
        cpu_if.cachemem_write = 1'b0;
        e = exp_q.pop_front();
        vectors++;
        if (!fin) begin
            errors++;
            $display("FAIL vec%0d timeout: busyWait stuck high", n);
        end
        if (e.rd) check($sformatf("vec%0d rdata", n), 32'(got),
                        32'(e.exp_rdata));
        check($sformatf("vec%0d miss", n), 32'(busy_seen), 32'(e.exp_miss));
        check($sformatf("vec%0d fetches", n), 32'(fetch_cnt - f0),
              32'(e.exp_miss));
        if (e.exp_miss)
            check($sformatf("vec%0d fetch_addr", n), 32'(last_fetch),
                  32'(e.fetch_addr));
        if (e.exp_wb) begin
            if (wb_q.size() == 0) begin
                errors++;
                $display("FAIL vec%0d wb: got none expected %h", n,
                         e.wb_data);
            end else begin
                w = wb_q.pop_front();
                check($sformatf("vec%0d wb_addr", n), 32'(w.a),
                      32'(e.wb_addr));
                check($sformatf("vec%0d wb_data", n), w.d, e.wb_data);
            end
        end else begin
            check($sformatf("vec%0d wb_count", n), 32'(wb_q.size()), 0);
            wb_q.delete();
        end
    endtask

    initial begin
        bit seen;
        vec_t rv;
        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = {8'(i) + 8'h30, 8'(i) + 8'h20,
                          8'(i) + 8'h10, 8'(i)};
        end
        mem_arr[4]   = 32'hDDCCBBAA;
        mem_arr[12]  = 32'h87654321;
        mem_arr[16]  = 32'h44332211;
        mem_arr[24]  = 32'hA0B0C0D0;
        mem_arr[255] = 32'h55667788;

        //          rd wr addr           wd     exp    ms wb wbaddr  wbdata        fetch
        vecs[0]  = '{1, 0, 32'h10,       8'h00, 8'hAA, 1, 0, 30'h0,  32'h0,        30'h4};
        vecs[1]  = '{1, 0, 32'h11,       8'h00, 8'hBB, 0, 0, 30'h0,  32'h0,        30'h0};
        vecs[2]  = '{1, 0, 32'h13,       8'h00, 8'hDD, 0, 0, 30'h0,  32'h0,        30'h0};
        vecs[3]  = '{1, 1, 32'h11,       8'hEE, 8'hBB, 0, 0, 30'h0,  32'h0,        30'h0};
        vecs[4]  = '{1, 0, 32'h11,       8'h00, 8'hBB, 0, 0, 30'h0,  32'h0,        30'h0};
        vecs[5]  = '{0, 1, 32'h12,       8'h5A, 8'h00, 0, 0, 30'h0,  32'h0,        30'h0};
        vecs[6]  = '{1, 0, 32'h12,       8'h00, 8'h5A, 0, 0, 30'h0,  32'h0,        30'h0};
        vecs[7]  = '{1, 0, 32'h30,       8'h00, 8'h21, 1, 1, 30'h4,  32'hDD5ABBAA, 30'hC};
        vecs[8]  = '{1, 1, 32'h31,       8'hEE, 8'h43, 0, 0, 30'h0,  32'h0,        30'h0};
        vecs[9]  = '{1, 0, 32'h10,       8'h00, 8'hAA, 1, 0, 30'h0,  32'h0,        30'h4};
        vecs[10] = '{1, 0, 32'h12,       8'h00, 8'h5A, 0, 0, 30'h0,  32'h0,        30'h0};
        vecs[11] = '{0, 1, 32'h40,       8'h77, 8'h00, 1, 0, 30'h0,  32'h0,        30'h10};
        vecs[12] = '{1, 0, 32'h40,       8'h00, 8'h77, 0, 0, 30'h0,  32'h0,        30'h0};
        vecs[13] = '{1, 0, 32'h41,       8'h00, 8'h22, 0, 0, 30'h0,  32'h0,        30'h0};
        vecs[14] = '{1, 0, 32'h60,       8'h00, 8'hD0, 1, 1, 30'h10, 32'h44332277, 30'h18};
        vecs[15] = '{1, 0, 32'hFFFFFFFF, 8'h00, 8'h55, 1, 0, 30'h0,  32'h0,        30'h3FFFFFFF};
        vecs[16] = '{1, 0, 32'h1F,       8'h00, 8'h37, 1, 0, 30'h0,  32'h0,        30'h7};
        vecs[17] = '{1, 0, 32'h1C,       8'h00, 8'h07, 0, 0, 30'h0,  32'h0,        30'h0};

        cpu_if.cachemem_read      = 1'b0;
        cpu_if.cachemem_write     = 1'b0;
        cpu_if.cachemem_address   = 32'h0;
        cpu_if.cachemem_writedata = 8'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        vectors++;
        check("reset rdata", 32'(cpu_if.cachemem_readdata), 0);
        check("reset busy", 32'(cpu_if.cachemem_busyWait), 0);
        check("reset mem_read", 32'(mem_if.mem_read), 0);
        check("reset mem_write", 32'(mem_if.mem_write), 0);

        for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

        // Reset while a fetch is outstanding.
        @(posedge clk);
        #1;
        cpu_if.cachemem_read    = 1'b1;
        cpu_if.cachemem_address = 32'h80;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (mem_if.mem_read) seen = 1'b1;
        end
        vectors++;
        check("rst_mid mem_read_seen", 32'(seen), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cpu_if.cachemem_read = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        vectors++;
        check("rst_mid mem_read", 32'(mem_if.mem_read), 0);
        check("rst_mid mem_write", 32'(mem_if.mem_write), 0);
        check("rst_mid busy", 32'(cpu_if.cachemem_busyWait), 0);
        wb_q.delete();

        rv = '{1, 0, 32'h60, 8'h00, 8'hD0, 1, 0, 30'h0, 32'h0, 30'h18};
        run_vec(rv, 18);
        rv = '{1, 0, 32'h80, 8'h00, 8'h20, 1, 0, 30'h0, 32'h0, 30'h20};
        run_vec(rv, 19);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule

// File: doc/dcache_byte_store.md
Name: dcache_byte_store

Overview:
- Byte-wide, direct-mapped, write-back, write-allocate data cache.
- Sits directly downstream of the data-memory access unit. That unit splits word, half-word and byte loads/stores into single-byte accesses; this block serves those accesses.
- Main memory sits behind it on a 32-bit block port with a busywait handshake.

Parameters:
- NUM_SETS, 8, number of cache lines; must be a power of two ≥ 2.
- BLOCK_BYTES, 4, bytes per line; fixed at 4 so one line equals one 32-bit memory beat.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- cachemem_read  in  1  byte read request.
- cachemem_write  in  1  byte write request.
- cachemem_address  in  32  byte address. Offset = [1:0]; index = [1+log2(NUM_SETS):2]; tag = remaining upper bits.
- cachemem_writedata  in  8  store byte.
- cachemem_readdata  out  8  load byte.
- cachemem_busyWait  out  1  request not yet complete; requester holds all inputs stable while high.
- mem_read  out  1  block fetch request.
- mem_write  out  1  block write-back request.
- mem_address  out  30  block address, equal to byte address [31:2].
- mem_writedata  out  32  evicted line, byte 0 in [7:0].
- mem_readdata  in  32  fetched line, byte 0 in [7:0].
- mem_busywait  in  1  memory busy.

Behaviour:
- Reset (synchronous):
  - All valid and dirty bits cleared; FSM to IDLE.
  - mem_read=0, mem_write=0, cachemem_busyWait=0, cachemem_readdata=0.
  - Data and tag contents undefined.
- Request = cachemem_read | cachemem_write. If both are high: serviced as a read; the array is never written.
- Hit = valid[index] & (tag[index]==addr tag).
- Read hit:
  - Zero wait states. cachemem_readdata = line byte [offset], combinational in the same cycle.
  - cachemem_busyWait stays 0.
- Write hit:
  - cachemem_busyWait stays 0.
  - Byte written and dirty[index] set at the next posedge.
  - Requester drops cachemem_write after that posedge.
- Miss:
  - cachemem_busyWait asserts combinationally in the request cycle.
  - It stays high until the hit cycle following refill.
- FSM states:
  - IDLE: on miss go to WRITE_BACK if dirty[index], else MEM_READ.
  - WRITE_BACK:
    - mem_write=1; mem_address={stored tag, index}; mem_writedata=stored line.
    - Completes at the first posedge in this state, after the entry cycle, with mem_busywait=0. Then go to MEM_READ.
  - MEM_READ:
    - mem_read=1; mem_address=cachemem_address[31:2].
    - Same completion rule. Then go to UPDATE.
  - UPDATE:
    - Line ← mem_readdata; tag written; valid=1; dirty=0.
    - mem_read/mem_write=0. Go to IDLE.
    - Request now hits and completes as above. A write-miss therefore ends as a write-hit, setting dirty.
- Miss latency: 1 (state entry) + memory wait + 1 (UPDATE) + hit cycle. Write-back adds its own transfer.
- mem_read and mem_write are never high together, and are never high in IDLE or UPDATE.
- Memory obligation: mem_busywait rises in the cycle after the request rises, or is already high. Completion is sampled only from the second cycle in a state onward.
- Request withdrawn mid-miss (inputs changed): the current memory transfer finishes. The FSM returns to IDLE and re-evaluates the new address.
- Reset mid-transfer:
  - The next cycle drops mem_read/mem_write and enters IDLE.
  - All lines are invalidated; dirty data is lost, with no flush.
- Index wrap: address 0xFFFF_FFFF maps to the top set, offset 3; no special casing.

Decomposition:
- Package dcache_pkg:
  - State enum {IDLE, WRITE_BACK, MEM_READ, UPDATE}.
  - OFFSET_BITS=2; functions deriving INDEX_BITS and TAG_BITS from NUM_SETS.
- Sub-module dcache_line_array:
  - Holds the data, tag, valid and dirty arrays.
  - Combinational read port, synchronous byte-write and line-fill ports, synchronous clear.
- FSM and hit logic stay in the top level.

Test Plan:
- Cold read miss:
  - Stimulus: after reset, read 0x0000_0010; memory returns 0xDDCCBBAA after 3 busy cycles.
  - Response: mem_read=1, mem_address=0x0000_0004, busyWait high throughout, then readdata=0xAA with busyWait=0. Reads of 0x11 and 0x13 return 0xBB and 0xDD with zero wait states and no memory traffic.
- Write hit:
  - Stimulus: write 0x5A to 0x0000_0012.
  - Response: no mem_read/mem_write, busyWait never high. A read of 0x12 returns 0x5A; the line is marked dirty.
- Dirty eviction:
  - Stimulus: read 0x0000_0030, same index 4, different tag.
  - Response: first mem_write with mem_address=0x0000_0004 and mem_writedata=0xDD5ABBAA. Then mem_read with mem_address=0x0000_000C; the requested byte is returned.
- Write-allocate miss:
  - Stimulus: write 0x77 to clean address 0x0000_0040; memory line 0x44332211.
  - Response: fetch occurs, no write-back. The line becomes 0x44332277, dirty. A later conflicting read writes back 0x44332277.
- Reset during MEM_READ:
  - Stimulus: assert reset for one cycle while mem_read=1.
  - Response: the next cycle has mem_read=0, busyWait=0, state IDLE. A repeat read of the same address misses again.
- Simultaneous read and write:
  - Stimulus: read=1, write=1 at 0x0000_0011 with data 0xEE.
  - Response: returns the stored byte (0xBB). A subsequent read confirms 0xBB, unchanged; the dirty bit is unchanged.
